dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Miss/writeback sequencer for the 4-line direct-mapped data cache, sitting between the MEM pipeline stage and main memory. It handles loads and stores, and stalls the pipeline on a miss. On a miss it writes back a dirty victim, invalidates it, fills the line from memory, and replays the access so it completes as a hit. It owns every control input of the cache array and the single memory port.

## Interface
Parameters:
- ADDR_W, 20, physical address width (`PHYSICAL_ADDR_WIDTH)
- LINE_W, 128, cache line width (`CACHE_LINE_WIDTH)

Ports:
- clk  in  1  clock; everything samples on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  access valid this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_op  in  2  `CACHE_OP_BYTE or `CACHE_OP_WORD
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_rdata  out  32  load data, valid while cpu_done=1
- cpu_stall  out  1  pipeline must hold all cpu_* inputs
- cpu_done  out  1  access completes this cycle
- c_addr_tag, c_addr_data  out  ADDR_W  cache address ports
- c_write_tag, c_write_data  out  1  cache write strobes
- c_op_type_data  out  2  cache data-port op
- c_din_tag, c_din_data  out  LINE_W  cache write data
- c_hit, c_dirty  in  1  cache tag-port status
- c_dout_tag  in  LINE_W  victim line
- c_dout_addr_tag  in  ADDR_W  victim line address
- c_dout_data  in  LINE_W  data-port read
- mem_req  out  1  memory request
- mem_we  out  1  1 = line write
- mem_addr  out  ADDR_W  line address, bits [3:0]=0
- mem_wdata  out  LINE_W  writeback line
- mem_rdata  in  LINE_W  fill line
- mem_ready  in  1  one-cycle completion pulse

## Operation
- c_addr_tag and c_addr_data are always driven from cpu_addr.
- c_op_type_data = cpu_op, except `CACHE_OP_CACHE_LINE in FILL.
- FSM states: LOOKUP, WB, INVAL, FILL, REFILL.

LOOKUP (reset state):
- No cpu_req: idle.
- cpu_req and c_hit:
  - cpu_done=1 and cpu_stall=0 in the same cycle.
  - Load: cpu_rdata = c_dout_data[31:0].
  - Store: c_write_data=1, c_din_data = {96'b0, cpu_wdata}.
- cpu_req, miss, c_dirty=1: cpu_stall=1, go to WB.
- cpu_req, miss, clean: cpu_stall=1, go to FILL.

WB:
- mem_req=1, mem_we=1, mem_addr = c_dout_addr_tag, mem_wdata = c_dout_tag.
- Both values are registered on entry and held stable until mem_ready.
- On mem_ready: go to INVAL.

INVAL:
- One cycle with c_write_tag=1. The cache clears the valid bit of a dirty line written through the tag port.
- Next state: FILL.

FILL:
- mem_req=1, mem_we=0, mem_addr = {cpu_addr[ADDR_W-1:4], 4'b0}.
- On mem_ready: c_write_tag=1 with c_din_tag = mem_rdata in that same cycle, then go to REFILL.

REFILL:
- One bubble cycle; cpu_stall=1.
- Next state: LOOKUP, where the replayed access hits.

Other rules:
- cpu_stall=1 in every state other than LOOKUP, and in LOOKUP on a miss.
- cpu_done is never 1 outside LOOKUP.
- mem_req drops in the cycle after mem_ready. mem_* are don't-care while mem_req=0.

## Timing
- Reset values: state=LOOKUP; all of the following are 0: cpu_stall, cpu_done, cpu_rdata, c_write_tag, c_write_data, mem_req, mem_we, mem_addr, mem_wdata.
- Hit: 0 added cycles.
- Clean miss: stall = 2 + memory latency, then the hit cycle.
- Dirty miss: stall = 3 + WB latency + FILL latency, then the hit cycle.
- mem_ready while mem_req=0 is ignored.
- reset mid-WB or mid-FILL: go to LOOKUP next edge, drop mem_req. The memory model must discard the aborted transaction. Cache contents are cleared by the cache's own reset.
- cpu_req deasserting while stalled is illegal; behaviour is undefined.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds outputs stat_hits, stat_misses, stat_wbs, each 32 bits.
  - The counters increment on, respectively: a hit cpu_done that is not the replay of a miss; a miss detected in LOOKUP; entry to WB.
  - Counters clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Clean load miss on addr 0x00040 with mem_ready 3 cycles after mem_req:
  - FILL mem_addr = 0x00040.
  - cpu_stall high for 5 cycles.
  - Then cpu_done with cpu_rdata = mem_rdata[31:0].
- Store hit: store word 0xDEADBEEF to 0x00044, then load 0x00044.
  - Store completes in 1 cycle with no stall.
  - Load returns 0xDEADBEEF.
- Dirty eviction: store to 0x00040 twice so the line is dirty, then load 0x00080 (same index).
  - WB with mem_addr = 0x00040 and the stored data in mem_wdata.
  - Then a one-cycle INVAL c_write_tag.
  - Then FILL with mem_addr = 0x00080.
- Byte load: load 0x00043 with cpu_op=`CACHE_OP_BYTE -> cpu_rdata[31:8] = 0.
- Reset asserted during FILL:
  - Next cycle: mem_req=0, cpu_stall=0, state=LOOKUP.
  - A late mem_ready is ignored.
- With DCACHE_STATS_EN, run the sequence above -> stat_hits, stat_misses and stat_wbs match the scoreboard counts.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: miss/writeback sequencer for a 4-line direct-mapped data cache.
// It sits between the MEM stage and main memory. It drives every control input
// of the cache array and the single memory port.
// On a miss it writes back a dirty victim, invalidates that victim, fills the
// line from memory, and then replays the access so that it completes as a hit.
//
// Build option: DCACHE_STATS_EN adds the 32-bit counters stat_hits,
// stat_misses and stat_wbs.
//
// CPU side handshake: cpu_req qualifies an access. While cpu_stall=1 the
// pipeline holds every cpu_* input stable. cpu_done=1 marks the single cycle in
// which the access completes; load data is valid only in that cycle.
// Memory side handshake: mem_req stays high with stable mem_* until a
// one-cycle mem_ready pulse. mem_ready while mem_req=0 is ignored.

module dcache_ctrl #(
   parameter int ADDR_W = 20,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_op,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_done,
   output logic [ADDR_W-1:0] c_addr_tag,
   output logic [ADDR_W-1:0] c_addr_data,
   output logic              c_write_tag,
   output logic              c_write_data,
   output logic [1:0]        c_op_type_data,
   output logic [LINE_W-1:0] c_din_tag,
   output logic [LINE_W-1:0] c_din_data,
   input  logic              c_hit,
   input  logic              c_dirty,
   input  logic [LINE_W-1:0] c_dout_tag,
   input  logic [ADDR_W-1:0] c_dout_addr_tag,
   input  logic [LINE_W-1:0] c_dout_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [2:0]        dbg_state
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses,
   output logic [31:0]       stat_wbs
`endif
);

   // Cache data-port op encoding shared with the cache array.
   localparam logic [1:0] OP_CACHE_LINE = 2'd2;

   typedef enum logic [2:0] {
      S_LOOKUP = 3'd0,
      S_WB     = 3'd1,
      S_INVAL  = 3'd2,
      S_FILL   = 3'd3,
      S_REFILL = 3'd4
   } state_t;

   state_t            state, next_state;
   logic [ADDR_W-1:0] wb_addr_q;
   logic [LINE_W-1:0] wb_data_q;

   // Loads only return the low word of the data port; the rest is not needed here.
   logic unused_dout_hi;
   assign unused_dout_hi = ^c_dout_data[LINE_W-1:32];

   // Both cache ports always follow the CPU address.
   assign c_addr_tag  = cpu_addr;
   assign c_addr_data = cpu_addr;
   assign dbg_state   = state;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_LOOKUP;
      else       state <= next_state;
   end

   // Capture the victim on the way into WB so that the memory sees a stable line
   // even though the cache outputs follow cpu_addr.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else if (state == S_LOOKUP && next_state == S_WB) begin
         wb_addr_q <= c_dout_addr_tag;
         wb_data_q <= c_dout_tag;
      end
   end

   // Next-state logic and all cache / memory / CPU control outputs.
   always_comb begin
      next_state     = state;
      cpu_stall      = 1'b0;
      cpu_done       = 1'b0;
      cpu_rdata      = '0;
      c_write_tag    = 1'b0;
      c_write_data   = 1'b0;
      c_op_type_data = cpu_op;
      c_din_tag      = '0;
      c_din_data     = '0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      case (state)
         S_LOOKUP: begin
            if (cpu_req) begin
               if (c_hit) begin
                  cpu_done = 1'b1;
                  if (cpu_we) begin
                     c_write_data = 1'b1;
                     c_din_data   = {{(LINE_W-32){1'b0}}, cpu_wdata};
                  end else begin
                     cpu_rdata = c_dout_data[31:0];
                  end
               end else begin
                  cpu_stall  = 1'b1;
                  next_state = c_dirty ? S_WB : S_FILL;
               end
            end
         end
         S_WB: begin
            cpu_stall = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wb_addr_q;
            mem_wdata = wb_data_q;
            if (mem_ready) next_state = S_INVAL;
         end
         S_INVAL: begin
            // A tag-port write on a dirty line clears its valid bit.
            cpu_stall   = 1'b1;
            c_write_tag = 1'b1;
            next_state  = S_FILL;
         end
         S_FILL: begin
            cpu_stall      = 1'b1;
            c_op_type_data = OP_CACHE_LINE;
            mem_req        = 1'b1;
            mem_addr       = {cpu_addr[ADDR_W-1:4], 4'b0};
            if (mem_ready) begin
               c_write_tag = 1'b1;
               c_din_tag   = mem_rdata;
               next_state  = S_REFILL;
            end
         end
         S_REFILL: begin
            // Bubble so the replayed access sees the freshly written line.
            cpu_stall  = 1'b1;
            next_state = S_LOOKUP;
         end
         default: next_state = S_LOOKUP;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic replay_q;

   // Event counters; the cycle after REFILL is the replay of a miss, so it is
   // not counted as a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         replay_q    <= 1'b0;
         stat_hits   <= '0;
         stat_misses <= '0;
         stat_wbs    <= '0;
      end else begin
         replay_q <= (state == S_REFILL);
         if (cpu_done && !replay_q)
            stat_hits <= stat_hits + 32'd1;
         if (state == S_LOOKUP && cpu_req && !c_hit)
            stat_misses <= stat_misses + 32'd1;
         if (state == S_LOOKUP && next_state == S_WB)
            stat_wbs <= stat_wbs + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: self-checking bench for dcache_ctrl with a behavioural
// 4-line cache array, a latency-programmable main memory and a scoreboard of
// expected load data. Build with DCACHE_STATS_EN to also check the counters.

module tb_dcache_ctrl;
   localparam int ADDR_W = 20;
   localparam int LINE_W = 128;

   localparam logic [1:0] OP_BYTE = 2'd0;
   localparam logic [1:0] OP_WORD = 2'd1;
   localparam logic [1:0] OP_LINE = 2'd2;

   localparam logic [2:0] ST_LOOKUP = 3'd0;
   localparam logic [2:0] ST_FILL   = 3'd3;

   logic              clk, reset;
   logic              cpu_req, cpu_we;
   logic [1:0]        cpu_op;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata, cpu_rdata;
   logic              cpu_stall, cpu_done;
   logic [ADDR_W-1:0] c_addr_tag, c_addr_data;
   logic              c_write_tag, c_write_data;
   logic [1:0]        c_op_type_data;
   logic [LINE_W-1:0] c_din_tag, c_din_data;
   logic              c_hit, c_dirty;
   logic [LINE_W-1:0] c_dout_tag;
   logic [ADDR_W-1:0] c_dout_addr_tag;
   logic [LINE_W-1:0] c_dout_data;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata, mem_rdata;
   logic              mem_ready;
   logic [2:0]        dbg_state;
`ifdef DCACHE_STATS_EN
   logic [31:0]       stat_hits, stat_misses, stat_wbs;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   int   mem_lat = 3;
   logic inject_ready = 1'b0;
   int   n_hits = 0, n_misses = 0, n_wbs = 0;

   logic [31:0] exp_q[$];

   dcache_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
      .c_addr_tag(c_addr_tag), .c_addr_data(c_addr_data),
      .c_write_tag(c_write_tag), .c_write_data(c_write_data), .c_op_type_data(c_op_type_data),
      .c_din_tag(c_din_tag), .c_din_data(c_din_data),
      .c_hit(c_hit), .c_dirty(c_dirty), .c_dout_tag(c_dout_tag),
      .c_dout_addr_tag(c_dout_addr_tag), .c_dout_data(c_dout_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .dbg_state(dbg_state)
`ifdef DCACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference memory content ----------------
   logic [127:0] main_mem[int];
   logic [31:0]  ref_word[int];

   function automatic logic [31:0] init_word(input logic [17:0] waddr);
      return 32'(32'h9E3779B9 * ({14'b0, waddr} + 32'd1));
   endfunction

   function automatic logic [127:0] mem_line(input logic [15:0] la);
      logic [127:0] l;
      if (main_mem.exists(int'(la))) return main_mem[int'(la)];
      for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word({la, 2'(i)});
      return l;
   endfunction

   function automatic logic [31:0] get_ref(input logic [17:0] waddr);
      if (ref_word.exists(int'(waddr))) return ref_word[int'(waddr)];
      return init_word(waddr);
   endfunction

   // ---------------- behavioural cache array ----------------
   logic [127:0] cl_data[4];
   logic [13:0]  cl_tag[4];
   logic         cl_v[4], cl_d[4];
   logic [1:0]   t_idx, d_idx;
   logic [31:0]  d_word;

   always_comb begin
      t_idx           = c_addr_tag[5:4];
      d_idx           = c_addr_data[5:4];
      c_hit           = cl_v[t_idx] && (cl_tag[t_idx] == c_addr_tag[19:6]);
      c_dirty         = cl_v[t_idx] && cl_d[t_idx];
      c_dout_tag      = cl_data[t_idx];
      c_dout_addr_tag = {cl_tag[t_idx], t_idx, 4'b0};
      d_word          = cl_data[d_idx][32*c_addr_data[3:2] +: 32];
      if (c_op_type_data == OP_BYTE) c_dout_data = {120'b0, d_word[8*c_addr_data[1:0] +: 8]};
      else                           c_dout_data = {96'b0, d_word};
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            cl_v[i] <= 1'b0;
            cl_d[i] <= 1'b0;
         end
      end else begin
         if (c_write_tag) begin
            if (cl_v[t_idx] && cl_d[t_idx]) begin
               cl_v[t_idx] <= 1'b0;
               cl_d[t_idx] <= 1'b0;
            end else begin
               cl_data[t_idx] <= c_din_tag;
               cl_tag[t_idx]  <= c_addr_tag[19:6];
               cl_v[t_idx]    <= 1'b1;
               cl_d[t_idx]    <= 1'b0;
            end
         end
         if (c_write_data) begin
            if (c_op_type_data == OP_BYTE)
               cl_data[d_idx][32*c_addr_data[3:2] + 8*c_addr_data[1:0] +: 8] <= c_din_data[7:0];
            else
               cl_data[d_idx][32*c_addr_data[3:2] +: 32] <= c_din_data[31:0];
            cl_d[d_idx] <= 1'b1;
         end
      end
   end

   // ---------------- main memory model ----------------
   int mem_cnt = 0;

   always @(posedge clk) begin
      #2;
      if (reset) begin
         mem_cnt   = 0;
         mem_ready = 1'b0;
      end else if (inject_ready) begin
         mem_ready = 1'b1;
      end else if (mem_ready || !mem_req) begin
         mem_ready = 1'b0;
         mem_cnt   = 0;
      end else begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            mem_ready = 1'b1;
            if (mem_we) main_mem[int'(mem_addr[19:4])] = mem_wdata;
            else        mem_rdata = mem_line(mem_addr[19:4]);
         end
      end
   end

   // ---------------- bench-side cache state tracker ----------------
   logic        trk_v[4], trk_d[4];
   logic [13:0] trk_tag[4];

   task automatic clear_tracker();
      for (int i = 0; i < 4; i++) begin
         trk_v[i]   = 1'b0;
         trk_d[i]   = 1'b0;
         trk_tag[i] = '0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver: one access with cycle-level monitoring ----------------
   task automatic do_access(input logic we, input logic [1:0] op,
                            input logic [19:0] addr, input logic [31:0] wdata);
      logic [1:0]   idx;
      logic [13:0]  tag;
      int           kind, exp_stall, stalls, invals, cyc;
      logic [19:0]  vict_addr, wb_addr_obs, fill_addr_obs;
      logic [127:0] vict_line, wb_data_obs;
      logic [31:0]  w;
      bit           done, wb_seen, wb_unstable, fill_seen, fill_op_bad;

      idx = addr[5:4];
      tag = addr[19:6];
      if (trk_v[idx] && trk_tag[idx] == tag)  kind = 0;
      else if (trk_v[idx] && trk_d[idx])      kind = 2;
      else                                    kind = 1;
      vict_addr = {trk_tag[idx], idx, 4'h0};
      for (int i = 0; i < 4; i++) vict_line[32*i +: 32] = get_ref({vict_addr[19:4], 2'(i)});

      w = get_ref(addr[19:2]);
      if (we) begin
         if (op == OP_WORD) w = wdata;
         else               w[8*addr[1:0] +: 8] = wdata[7:0];
         ref_word[int'(addr[19:2])] = w;
      end else begin
         exp_q.push_back((op == OP_WORD) ? w : {24'b0, w[8*addr[1:0] +: 8]});
      end

      if (kind != 0) begin
         trk_v[idx]   = 1'b1;
         trk_tag[idx] = tag;
         trk_d[idx]   = 1'b0;
      end
      if (we) trk_d[idx] = 1'b1;
      if (kind == 0) n_hits++;
      else           n_misses++;
      if (kind == 2) n_wbs++;
      exp_stall = (kind == 0) ? 0 : (kind == 1) ? 2 + mem_lat : 3 + 2 * mem_lat;

      @(posedge clk);
      #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_op    = op;
      cpu_addr  = addr;
      cpu_wdata = wdata;

      done = 0; wb_seen = 0; wb_unstable = 0; fill_seen = 0; fill_op_bad = 0;
      stalls = 0; invals = 0; cyc = 0;
      wb_addr_obs = '0; wb_data_obs = '0; fill_addr_obs = '0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cpu_done) begin
            done = 1;
            check("done_stall", cpu_stall, 1'b0);
            check("done_state", dbg_state, ST_LOOKUP);
            check("done_op", c_op_type_data, op);
            if (we) begin
               check("st_wr", c_write_data, 1'b1);
               check("st_din", c_din_data[31:0], wdata);
            end else begin
               check("sb_nonempty", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) check("ld_rdata", cpu_rdata, exp_q.pop_front());
            end
         end else begin
            if (cpu_stall) stalls++;
            if (mem_req && mem_we) begin
               if (!wb_seen) begin
                  wb_seen     = 1;
                  wb_addr_obs = mem_addr;
                  wb_data_obs = mem_wdata;
               end else if (mem_addr != wb_addr_obs || mem_wdata != wb_data_obs) begin
                  wb_unstable = 1;
               end
            end
            if (c_write_tag && !mem_req) invals++;
            if (mem_req && !mem_we) begin
               if (!fill_seen) begin
                  fill_seen     = 1;
                  fill_addr_obs = mem_addr;
               end
               if (c_op_type_data != OP_LINE) fill_op_bad = 1;
            end
         end
      end
      check("done_seen", done, 1'b1);
      check("stall_cycles", stalls, exp_stall);
      check("wb_seen", wb_seen, kind == 2);
      check("fill_seen", fill_seen, kind != 0);
      check("fill_op", fill_op_bad, 1'b0);
      if (kind == 2) begin
         check("wb_addr", wb_addr_obs, vict_addr);
         check("wb_data", wb_data_obs, vict_line);
         check("wb_stable", wb_unstable, 1'b0);
         check("inval_cycles", invals, 1);
      end
      if (kind != 0) check("fill_addr", fill_addr_obs, {addr[19:4], 4'b0});

      @(posedge clk);
      #1;
      cpu_req = 1'b0;
   endtask

`ifdef DCACHE_STATS_EN
   task automatic check_stats();
      check("stat_hits", stat_hits, n_hits);
      check("stat_misses", stat_misses, n_misses);
      check("stat_wbs", stat_wbs, n_wbs);
   endtask
`endif

   // ---------------- main sequence ----------------
   initial begin
      logic [19:0] a;
      logic        rwe;
      logic [1:0]  rop;
      int          cyc;

      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_op = OP_WORD; cpu_addr = '0; cpu_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      clear_tracker();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", dbg_state, ST_LOOKUP);
      check("rst_stall", cpu_stall, 1'b0);
      check("rst_done", cpu_done, 1'b0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_wtag", c_write_tag, 1'b0);
      check("rst_wdata", c_write_data, 1'b0);
      check("rst_mreq", mem_req, 1'b0);
      check("rst_mwe", mem_we, 1'b0);
      check("rst_maddr", mem_addr, 20'h0);
      check("rst_mwdata", mem_wdata, 128'h0);
`ifdef DCACHE_STATS_EN
      check_stats();
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;

      // clean load miss, memory answers 3 cycles after the request
      mem_lat = 3;
      do_access(1'b0, OP_WORD, 20'h00040, 32'h0);
      // store hit then load it back
      do_access(1'b1, OP_WORD, 20'h00044, 32'hDEADBEEF);
      do_access(1'b0, OP_WORD, 20'h00044, 32'h0);
      // dirty the line, then evict it from the same index
      do_access(1'b1, OP_WORD, 20'h00040, 32'h12345678);
      do_access(1'b1, OP_WORD, 20'h00040, 32'hCAFEF00D);
      do_access(1'b0, OP_WORD, 20'h00080, 32'h0);
      // bring the written-back line back and read a byte out of it
      do_access(1'b0, OP_WORD, 20'h00040, 32'h0);
      do_access(1'b0, OP_BYTE, 20'h00043, 32'h0);

      // random mix across 4 tags x 4 indices
      for (int n = 0; n < 40; n++) begin
         mem_lat = $urandom_range(1, 4);
         rwe = 1'($urandom_range(0, 1));
         rop = ($urandom_range(0, 2) == 0) ? OP_BYTE : OP_WORD;
         a   = {12'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'b00};
         if (rop == OP_BYTE) a[1:0] = 2'($urandom_range(0, 3));
         do_access(rwe, rop, a, $urandom());
      end
`ifdef DCACHE_STATS_EN
      check_stats();
`endif

      // reset in the middle of a fill
      mem_lat = 6;
      @(posedge clk);
      #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_op = OP_WORD; cpu_addr = 20'h01000;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (dbg_state != ST_FILL && cyc < 100);
      check("reach_fill", dbg_state, ST_FILL);
      reset = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      check("abort_mreq", mem_req, 1'b0);
      check("abort_stall", cpu_stall, 1'b0);
      check("abort_state", dbg_state, ST_LOOKUP);
      reset = 1'b0;
      clear_tracker();
      ref_word.delete();
      main_mem.delete();
      n_hits = 0; n_misses = 0; n_wbs = 0;
`ifdef DCACHE_STATS_EN
      check_stats();
`endif
      // a stray mem_ready with no request outstanding must be ignored
      @(posedge clk);
      #1;
      inject_ready = 1'b1;
      @(negedge clk);
      check("late_rdy_state", dbg_state, ST_LOOKUP);
      check("late_rdy_mreq", mem_req, 1'b0);
      check("late_rdy_done", cpu_done, 1'b0);
      @(posedge clk);
      #1;
      inject_ready = 1'b0;
      @(negedge clk);
      check("late_rdy_after", dbg_state, ST_LOOKUP);

      // recovery access after the aborted one
      mem_lat = 2;
      do_access(1'b0, OP_WORD, 20'h01000, 32'h0);
`ifdef DCACHE_STATS_EN
      check_stats();
`endif
      check("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
